// File: rtl/lc3b_types.sv
// Shared types for the L2 write buffer slice.
//   lc3b_word          16-bit line/byte address
//   lc3b_cacheline     128-bit cache line
//   lc3b_l2wb_state_t  write-buffer controller state
package lc3b_types;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned LINE_W = 128;

  typedef logic [WORD_W-1:0] lc3b_word;
  typedef logic [LINE_W-1:0] lc3b_cacheline;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_L2 = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } lc3b_l2wb_state_t;

endpackage

// File: rtl/l2_write_buffer_datapath.sv
// Storage for the single buffered line plus the read-return register,
// tag hit compare and the upstream idle counter.
// Ports:
//   clk, reset            clock / async active-high reset
//   addr_tag              tag bits of the upstream address
//   wdata                 upstream write line
//   l2_rdata              line returned by L2 on a read miss
//   capture_line          load tag/data, set valid
//   load_rdata_buf        rdata_reg <= buffered line (read hit)
//   load_rdata_l2         rdata_reg <= l2_rdata (read miss return)
//   clear_valid           drop the buffered line after a drain
//   cnt_inc, cnt_clr      idle counter control
//   hit, buf_valid        buffer status
//   buf_tag, buf_data     buffered line
//   rdata_reg             data returned upstream
//   idle_expired          idle counter has reached DRAIN_DELAY
module l2_write_buffer_datapath
  import lc3b_types::*;
#(
  parameter int unsigned OFFSET_BITS = 4,
  parameter int unsigned DRAIN_DELAY = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [15-OFFSET_BITS:0]   addr_tag,
  input  lc3b_cacheline             wdata,
  input  lc3b_cacheline             l2_rdata,
  input  logic                      capture_line,
  input  logic                      load_rdata_buf,
  input  logic                      load_rdata_l2,
  input  logic                      clear_valid,
  input  logic                      cnt_inc,
  input  logic                      cnt_clr,
  output logic                      hit,
  output logic                      buf_valid,
  output logic [15-OFFSET_BITS:0]   buf_tag,
  output lc3b_cacheline             buf_data,
  output lc3b_cacheline             rdata_reg,
  output logic                      idle_expired
);

  localparam int unsigned CNT_W = (DRAIN_DELAY < 1) ? 1 : $clog2(DRAIN_DELAY + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DRAIN_DELAY);

  logic [CNT_W-1:0] idle_cnt;

  assign hit          = buf_valid && (addr_tag == buf_tag);
  assign idle_expired = (idle_cnt == CNT_LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      buf_data  <= '0;
    end else if (capture_line) begin
      buf_valid <= 1'b1;
      buf_tag   <= addr_tag;
      buf_data  <= wdata;
    end else if (clear_valid) begin
      buf_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_reg <= '0;
    end else if (load_rdata_buf) begin
      rdata_reg <= buf_data;
    end else if (load_rdata_l2) begin
      rdata_reg <= l2_rdata;
    end
  end

  // Saturates at the limit so a long idle stretch can never wrap back
  // below DRAIN_DELAY.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if (cnt_clr) begin
      idle_cnt <= '0;
    end else if (cnt_inc && (idle_cnt != CNT_LIMIT)) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/l2_write_buffer.sv
// Single-entry write-back buffer between the memory arbiter and L2.
// Writebacks are absorbed and acknowledged immediately, reads hitting the
// buffered line are served locally, read misses bypass to L2, and the line
// drains to L2 after DRAIN_DELAY idle cycles or when a different line must
// be written.
// Ports:
//   clk, reset                          clock / async active-high reset
//   arb_l2_address/_mem_read/_mem_write/_wdata   upstream request
//   l2arb_rdata, l2arb_mem_resp         upstream response
//   wb_l2_address/_mem_read/_mem_write/_wdata    downstream request
//   l2_wb_rdata, l2_wb_mem_resp         downstream response
module l2_write_buffer
  import lc3b_types::*;
#(
  parameter int unsigned OFFSET_BITS = 4,
  parameter int unsigned DRAIN_DELAY = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  lc3b_word      arb_l2_address,
  input  logic          arb_l2_mem_read,
  input  logic          arb_l2_mem_write,
  input  lc3b_cacheline arb_l2_wdata,
  output lc3b_cacheline l2arb_rdata,
  output logic          l2arb_mem_resp,
  output lc3b_word      wb_l2_address,
  output logic          wb_l2_mem_read,
  output logic          wb_l2_mem_write,
  output lc3b_cacheline wb_l2_wdata,
  input  lc3b_cacheline l2_wb_rdata,
  input  logic          l2_wb_mem_resp
);

  lc3b_l2wb_state_t state, state_next;

  logic                    is_read, is_write;
  logic                    hit, buf_valid, idle_expired;
  logic [15-OFFSET_BITS:0] buf_tag;
  logic                    capture_line, load_rdata_buf, load_rdata_l2;
  logic                    clear_valid, cnt_inc, cnt_clr;

  // A simultaneous read and write is handled as a write.
  assign is_write = arb_l2_mem_write;
  assign is_read  = arb_l2_mem_read && !arb_l2_mem_write;

  l2_write_buffer_datapath #(
    .OFFSET_BITS (OFFSET_BITS),
    .DRAIN_DELAY (DRAIN_DELAY)
  ) u_datapath (
    .clk            (clk),
    .reset          (reset),
    .addr_tag       (arb_l2_address[15:OFFSET_BITS]),
    .wdata          (arb_l2_wdata),
    .l2_rdata       (l2_wb_rdata),
    .capture_line   (capture_line),
    .load_rdata_buf (load_rdata_buf),
    .load_rdata_l2  (load_rdata_l2),
    .clear_valid    (clear_valid),
    .cnt_inc        (cnt_inc),
    .cnt_clr        (cnt_clr),
    .hit            (hit),
    .buf_valid      (buf_valid),
    .buf_tag        (buf_tag),
    .buf_data       (wb_l2_wdata),
    .rdata_reg      (l2arb_rdata),
    .idle_expired   (idle_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (is_write) begin
          // A write to a different line must first push the old one out;
          // the write itself is picked up on the return to IDLE.
          state_next = (!buf_valid || hit) ? RESP : DRAIN;
        end else if (is_read) begin
          state_next = hit ? RESP : RD_L2;
        end else if (buf_valid && idle_expired) begin
          state_next = DRAIN;
        end
      end
      RD_L2:   if (l2_wb_mem_resp) state_next = RESP;
      DRAIN:   if (l2_wb_mem_resp) state_next = IDLE;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    l2arb_mem_resp  = 1'b0;
    wb_l2_mem_read  = 1'b0;
    wb_l2_mem_write = 1'b0;
    wb_l2_address   = '0;
    capture_line    = 1'b0;
    load_rdata_buf  = 1'b0;
    load_rdata_l2   = 1'b0;
    clear_valid     = 1'b0;
    cnt_inc         = 1'b0;
    cnt_clr         = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_clr        = is_write || is_read;
        capture_line   = is_write && (!buf_valid || hit);
        load_rdata_buf = is_read && hit;
        cnt_inc        = !is_write && !is_read && buf_valid && !idle_expired;
      end
      RD_L2: begin
        wb_l2_mem_read = 1'b1;
        wb_l2_address  = arb_l2_address;
        load_rdata_l2  = l2_wb_mem_resp;
      end
      DRAIN: begin
        wb_l2_mem_write = 1'b1;
        wb_l2_address   = {buf_tag, {OFFSET_BITS{1'b0}}};
        clear_valid     = l2_wb_mem_resp;
        cnt_clr         = l2_wb_mem_resp;
      end
      RESP: begin
        l2arb_mem_resp = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_l2_write_buffer.sv
// Scoreboard bench: the driver pushes expected upstream responses and
// expected L2 transactions into queues; an upstream monitor and an L2
// responder model pop and compare as the DUT presents them.
module tb_l2_write_buffer;

  logic          clk;
  logic          reset;
  logic [15:0]   arb_l2_address;
  logic          arb_l2_mem_read;
  logic          arb_l2_mem_write;
  logic [127:0]  arb_l2_wdata;
  logic [127:0]  l2arb_rdata;
  logic          l2arb_mem_resp;
  logic [15:0]   wb_l2_address;
  logic          wb_l2_mem_read;
  logic          wb_l2_mem_write;
  logic [127:0]  wb_l2_wdata;
  logic [127:0]  l2_wb_rdata;
  logic          l2_wb_mem_resp;

  l2_write_buffer dut (
    .clk              (clk),
    .reset            (reset),
    .arb_l2_address   (arb_l2_address),
    .arb_l2_mem_read  (arb_l2_mem_read),
    .arb_l2_mem_write (arb_l2_mem_write),
    .arb_l2_wdata     (arb_l2_wdata),
    .l2arb_rdata      (l2arb_rdata),
    .l2arb_mem_resp   (l2arb_mem_resp),
    .wb_l2_address    (wb_l2_address),
    .wb_l2_mem_read   (wb_l2_mem_read),
    .wb_l2_mem_write  (wb_l2_mem_write),
    .wb_l2_wdata      (wb_l2_wdata),
    .l2_wb_rdata      (l2_wb_rdata),
    .l2_wb_mem_resp   (l2_wb_mem_resp)
  );

  localparam logic [127:0] LINE_A = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
  localparam logic [127:0] LINE_B = 128'hBBBB_1111_BBBB_2222_BBBB_3333_BBBB_4444;
  localparam logic [127:0] LINE_C = 128'hCCCC_5555_CCCC_6666_CCCC_7777_CCCC_8888;
  localparam logic [127:0] LINE_D = 128'hDDDD_9999_DDDD_AAAA_DDDD_BBBB_DDDD_CCCC;
  localparam logic [127:0] LINE_E = 128'hEEEE_0F0F_EEEE_1E1E_EEEE_2D2D_EEEE_3C3C;
  localparam logic [127:0] LINE_F = 128'hF00D_FACE_F00D_FACE_F00D_FACE_F00D_FACE;

  typedef struct {
    logic [127:0] rdata;
    bit           chk_data;
    int           req_cyc;
    int           lat;
  } up_exp_t;

  typedef struct {
    bit           is_wr;
    logic [15:0]  addr;
    logic [127:0] data;   // write: expected line; read: line to return
    int           lat;
    int           start;  // expected first cycle of the request, -1 = any
  } l2_exp_t;

  up_exp_t up_q[$];
  l2_exp_t l2_q[$];

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total = n_total + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Upstream monitor
  initial forever begin
    @(negedge clk);
    if (!reset && l2arb_mem_resp) begin
      if (up_q.size() == 0) begin
        chk("unexpected_up_resp", 1'b1, 1'b0);
      end else begin
        up_exp_t e;
        e = up_q.pop_front();
        if (e.chk_data) chk("up_rdata", l2arb_rdata, e.rdata);
        chk("up_latency", 128'(cyc - e.req_cyc), 128'(e.lat));
      end
    end
  end

  // L2 responder: checks each new request against the queue, then answers
  // in the lat-th cycle of the request.
  initial begin
    bit           active;
    int           cnt;
    int           cur_lat;
    logic [127:0] cur_rdata;
    active = 1'b0;
    cnt = 0;
    cur_lat = 1;
    cur_rdata = '0;
    l2_wb_mem_resp = 1'b0;
    l2_wb_rdata = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        active = 1'b0;
        cnt = 0;
        l2_wb_mem_resp = 1'b0;
      end else if (wb_l2_mem_read || wb_l2_mem_write) begin
        if (!active) begin
          active = 1'b1;
          cnt = 0;
          chk("l2_rd_wr_exclusive", 128'(wb_l2_mem_read && wb_l2_mem_write), 128'(0));
          if (l2_q.size() == 0) begin
            chk("unexpected_l2_req", 1'b1, 1'b0);
            cur_lat = 1;
            cur_rdata = '0;
          end else begin
            l2_exp_t e;
            e = l2_q.pop_front();
            chk("l2_is_write", 128'(wb_l2_mem_write), 128'(e.is_wr));
            chk("l2_address", 128'(wb_l2_address), 128'(e.addr));
            if (e.is_wr) chk("l2_wdata", wb_l2_wdata, e.data);
            if (e.start >= 0) chk("l2_start_cycle", 128'(cyc), 128'(e.start));
            cur_lat = e.lat;
            cur_rdata = e.data;
          end
        end
        cnt = cnt + 1;
        if (cnt == cur_lat) begin
          l2_wb_mem_resp = 1'b1;
          l2_wb_rdata = cur_rdata;
        end else begin
          l2_wb_mem_resp = 1'b0;
        end
      end else begin
        active = 1'b0;
        l2_wb_mem_resp = 1'b0;
      end
    end
  end

  task automatic do_req(input bit rd, input bit wr, input logic [15:0] a,
                        input logic [127:0] d, input logic [127:0] exp_rd,
                        input bit chk_d, input int lat, output int rcyc);
    up_exp_t e;
    bit seen;
    @(negedge clk);
    e.rdata = exp_rd;
    e.chk_data = chk_d;
    e.req_cyc = cyc;
    e.lat = lat;
    up_q.push_back(e);
    arb_l2_address = a;
    arb_l2_mem_read = rd;
    arb_l2_mem_write = wr;
    arb_l2_wdata = d;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (l2arb_mem_resp) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("up_resp_timeout", 1'b0, 1'b1);
    arb_l2_mem_read = 1'b0;
    arb_l2_mem_write = 1'b0;
    rcyc = cyc;
  endtask

  task automatic push_l2(input bit is_wr, input logic [15:0] a, input logic [127:0] d,
                         input int lat, input int start);
    l2_exp_t e;
    e.is_wr = is_wr;
    e.addr = a;
    e.data = d;
    e.lat = lat;
    e.start = start;
    l2_q.push_back(e);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int r;
    int k;
    reset = 1'b1;
    arb_l2_address = '0;
    arb_l2_mem_read = 1'b0;
    arb_l2_mem_write = 1'b0;
    arb_l2_wdata = '0;

    idle_cycles(2);
    chk("rst_mem_resp", 128'(l2arb_mem_resp), 128'(0));
    chk("rst_wb_read", 128'(wb_l2_mem_read), 128'(0));
    chk("rst_wb_write", 128'(wb_l2_mem_write), 128'(0));
    chk("rst_wb_address", 128'(wb_l2_address), 128'(0));
    chk("rst_rdata", l2arb_rdata, 128'(0));
    chk("rst_wdata", wb_l2_wdata, 128'(0));
    reset = 1'b0;

    // Write to empty buffer, idle drain 4 cycles after resp, then a read
    // of the same line must go to L2 because the buffer emptied.
    do_req(1'b0, 1'b1, 16'h1230, LINE_A, '0, 1'b0, 1, r);
    push_l2(1'b1, 16'h1230, LINE_A, 2, r + 4);
    idle_cycles(8);
    push_l2(1'b0, 16'h1230, LINE_E, 1, -1);
    do_req(1'b1, 1'b0, 16'h1230, '0, LINE_E, 1'b1, 2, r);

    // Read hit served from the buffer.
    do_req(1'b0, 1'b1, 16'h1230, LINE_A, '0, 1'b0, 1, r);
    do_req(1'b1, 1'b0, 16'h1238, '0, LINE_A, 1'b1, 1, r);
    push_l2(1'b1, 16'h1230, LINE_A, 2, r + 4);
    idle_cycles(8);

    // Coalescing writes to the same line: one drain of the newer data.
    do_req(1'b0, 1'b1, 16'h1230, LINE_A, '0, 1'b0, 1, r);
    do_req(1'b0, 1'b1, 16'h1234, LINE_B, '0, 1'b0, 1, r);
    push_l2(1'b1, 16'h1230, LINE_B, 2, r + 4);
    idle_cycles(8);

    // Write miss while full: drain A (latency 3), then capture C.
    do_req(1'b0, 1'b1, 16'h1230, LINE_A, '0, 1'b0, 1, r);
    push_l2(1'b1, 16'h1230, LINE_A, 3, r + 2);
    do_req(1'b0, 1'b1, 16'h4560, LINE_C, '0, 1'b0, 5, r);
    push_l2(1'b1, 16'h4560, LINE_C, 1, r + 4);
    idle_cycles(8);

    // Read miss bypasses the held line; the held line drains afterwards.
    do_req(1'b0, 1'b1, 16'h1230, LINE_A, '0, 1'b0, 1, r);
    push_l2(1'b0, 16'h7770, LINE_D, 3, r + 2);
    do_req(1'b1, 1'b0, 16'h7770, '0, LINE_D, 1'b1, 4, r);
    push_l2(1'b1, 16'h1230, LINE_A, 2, r + 4);
    idle_cycles(8);

    // Read and write together count as a write.
    do_req(1'b1, 1'b1, 16'h2220, LINE_F, '0, 1'b0, 1, r);
    push_l2(1'b1, 16'h2220, LINE_F, 1, r + 4);
    idle_cycles(8);

    // Reset in the middle of a drain that L2 never answers.
    do_req(1'b0, 1'b1, 16'h1230, LINE_A, '0, 1'b0, 1, r);
    push_l2(1'b1, 16'h1230, LINE_A, 50, r + 4);
    k = 0;
    while (!wb_l2_mem_write && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("drain_started", 128'(wb_l2_mem_write), 128'(1));
    idle_cycles(2);
    #1 reset = 1'b1;
    #1;
    chk("rst_drops_l2_write", 128'(wb_l2_mem_write), 128'(0));
    chk("rst_drops_l2_addr", 128'(wb_l2_address), 128'(0));
    chk("rst_clears_wdata", wb_l2_wdata, 128'(0));
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    idle_cycles(10);
    push_l2(1'b0, 16'h1230, LINE_E, 2, -1);
    do_req(1'b1, 1'b0, 16'h1230, '0, LINE_E, 1'b1, 3, r);
    idle_cycles(10);

    chk("up_queue_drained", 128'(up_q.size()), 128'(0));
    chk("l2_queue_drained", 128'(l2_q.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
